// File: rtl/icache_direct_pkg.sv
// Shared definitions for the direct-mapped instruction cache: geometry defaults,
// tag-width derivation and the controller state encoding.
package icache_direct_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int IDX_W_DEF  = 8;
  localparam int ADDR_W_DEF = 18;

  // Tag covers the used address bits above the index and the byte offset.
  function automatic int tag_w(input int idx_w, input int addr_w);
    return addr_w - idx_w - 2;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

endpackage

// File: rtl/icache_array.sv
// Line storage for icache_direct: valid bits with async reset, tag and data
// arrays, one combinational read port and one synchronous write port.
module icache_array
  import icache_direct_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int TAG_W = tag_w(IDX_W_DEF, ADDR_W_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  localparam int LINES = 2 ** IDX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= TRUE;
    end
  end

  // Tag and data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped one-word-per-line instruction cache with single-cycle hits and
// a one-word miss path to the memory controller. ICACHE_STAT_EN adds hit/miss counters.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        clear,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_enable,
  input  logic [31:0] mem_inst,
`ifdef ICACHE_STAT_EN
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
`endif
  output state_t      dbg_state
);

  localparam int TAG_W = tag_w(IDX_W, ADDR_W);

  // Handshake: mem_valid is a level request held while in MISS; the controller
  // answers with a one-cycle mem_enable carrying mem_inst, which also retires
  // the request in that same cycle.

  state_t state_q, state_d;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             hit;
  logic             lookup;
  logic             fill;

  icache_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (if_pc[IDX_W+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill),
    .wr_idx   (mem_addr[IDX_W+1:2]),
    .wr_tag   (mem_addr[ADDR_W-1:IDX_W+2]),
    .wr_data  (mem_inst)
  );

  assign hit = rd_valid && (rd_tag == if_pc[ADDR_W-1:IDX_W+2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rdy) begin
      if (clear) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE:    if (if_req && !hit) state_d = MISS;
          MISS:    if (mem_enable) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Fill ignores clear: the returned word is still correct, it is just not forwarded.
  always_comb begin
    mem_valid = (state_q == MISS) && !mem_enable && !clear;
    lookup    = rdy && !clear && (state_q == IDLE) && if_req;
    fill      = rdy && (state_q == MISS) && mem_enable;
  end

  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_valid <= FALSE;
      inst       <= '0;
      mem_addr   <= '0;
    end else begin
      inst_valid <= FALSE;
      if (lookup) begin
        if (hit) begin
          inst       <= rd_data;
          inst_valid <= TRUE;
        end else begin
          mem_addr <= {if_pc[31:2], 2'b00};
        end
      end else if (fill && !clear) begin
        inst       <= mem_inst;
        inst_valid <= TRUE;
      end
    end
  end

`ifdef ICACHE_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (lookup) begin
      if (hit && stat_hits != 32'hFFFF_FFFF) begin
        stat_hits <= stat_hits + 32'd1;
      end else if (!hit && stat_misses != 32'hFFFF_FFFF) begin
        stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`endif

  // Address bits outside the index/tag window are intentionally not compared.
  logic unused_bits;
  assign unused_bits = ^{if_pc[31:ADDR_W], if_pc[1:0], mem_addr[31:ADDR_W], mem_addr[1:0]};

endmodule
